subc_restoring_div: RTL and testbench



---
 rtl/subc_restoring_div.sv | 176 +++++++++++++++++
 tb/tb_subc_restoring_div.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/subc_restoring_div.sv
// rtl/subc_restoring_div.sv - iterative unsigned restoring divider reusing one SubC subtractor
// Optional macro SUBC_RESTORING_DIV_DIVZERO_FAST_EN: zero divisor skips straight to DONE.

module subc #(
    parameter int width = 9,
    parameter int speed = 0
) (
    input  logic [width-1:0] a_i,
    input  logic [width-1:0] b_i,
    input  logic             ci_i,
    output logic [width-1:0] s_o,
    output logic             co_o
);
    localparam int LG = $clog2(width);

    logic [width-1:0] g;
    logic [width-1:0] p;
    logic [width-1:0] x;
    logic [width-1:0] c;

    // A - B - CI computed as A + ~B + ~CI; co_o is the borrow (inverted carry).
    always_comb begin
        int j;
        j = 0;
        x = a_i ^ ~b_i;
        g = a_i & ~b_i;
        p = x;
        g[0] = g[0] | (p[0] & ~ci_i);
        if (speed == 1) begin
            for (int l = 0; l < LG; l++) begin
                for (int i = (2 << l) - 1; i < width; i += (2 << l)) begin
                    j = i - (1 << l);
                    g[i] = g[i] | (p[i] & g[j]);
                    p[i] = p[i] & p[j];
                end
            end
            for (int l = LG - 1; l >= 0; l--) begin
                for (int i = 3 * (1 << l) - 1; i < width; i += (2 << l)) begin
                    j = i - (1 << l);
                    g[i] = g[i] | (p[i] & g[j]);
                    p[i] = p[i] & p[j];
                end
            end
        end else if (speed == 2) begin
            for (int l = 0; l < LG; l++) begin
                for (int i = 0; i < width; i++) begin
                    if (((i >> l) & 1) == 1) begin
                        j = ((i >> l) << l) - 1;
                        g[i] = g[i] | (p[i] & g[j]);
                        p[i] = p[i] & p[j];
                    end
                end
            end
        end else begin
            for (int i = 1; i < width; i++) begin
                g[i] = g[i] | (p[i] & g[i-1]);
                p[i] = p[i] & p[i-1];
            end
        end
        c = {g[width-2:0], ~ci_i};
        s_o = x ^ c;
        co_o = ~g[width-1];
    end
endmodule

module subc_restoring_div #(
    parameter int width = 8,
    parameter int speed = 0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [width-1:0] dividend_i,
    input  logic [width-1:0] divisor_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [width-1:0] quotient_o,
    output logic [width-1:0] remainder_o,
    output logic             div_zero_o,
    output logic             busy_o
);
    localparam int CW = $clog2(width + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [width-1:0] r_q, r_d;
    logic [width-1:0] q_q, q_d;
    logic [width-1:0] d_q, d_d;
    logic [CW-1:0]    count_q, count_d;
    logic             dz_q, dz_d;

    logic [width:0]   sub_s;
    logic             sub_co;
    logic             unused_sub_msb;

    subc #(.width(width + 1), .speed(speed)) u_subc (
        .a_i  ({r_q, q_q[width-1]}),
        .b_i  ({1'b0, d_q}),
        .ci_i (1'b0),
        .s_o  (sub_s),
        .co_o (sub_co)
    );

    // The trial difference always fits in width bits when no borrow occurs.
    assign unused_sub_msb = sub_s[width];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            count_q <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            count_q <= count_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        count_d = count_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    r_d     = '0;
                    q_d     = dividend_i;
                    d_d     = divisor_i;
                    dz_d    = (divisor_i == '0);
                    count_d = CW'(width);
                    state_d = RUN;
`ifdef SUBC_RESTORING_DIV_DIVZERO_FAST_EN
                    if (divisor_i == '0) begin
                        q_d     = '1;
                        r_d     = dividend_i;
                        state_d = DONE;
                    end
`endif
                end
            end
            RUN: begin
                // Borrow means the shifted remainder is below D and its MSB is zero.
                r_d     = sub_co ? {r_q[width-2:0], q_q[width-1]} : sub_s[width-1:0];
                q_d     = {q_q[width-2:0], ~sub_co};
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign busy_o      = (state_q != IDLE);
    assign quotient_o  = q_q;
    assign remainder_o = r_q;
    assign div_zero_o  = dz_q;
endmodule

// File: tb/tb_subc_restoring_div.sv
// tb/tb_subc_restoring_div.sv - directed and randomized checks of subc_restoring_div against / and %

module tb_subc_restoring_div;
`ifdef SUBC_RESTORING_DIV_DIVZERO_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       in_valid8, in_ready8, out_valid8, out_ready8, dz8, busy8;
    logic [7:0] a8, b8, q8, r8;

    subc_restoring_div #(.width(8), .speed(0)) dut8 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid8), .in_ready_o(in_ready8),
        .dividend_i(a8), .divisor_i(b8), .out_valid_o(out_valid8), .out_ready_i(out_ready8),
        .quotient_o(q8), .remainder_o(r8), .div_zero_o(dz8), .busy_o(busy8)
    );

    logic        in_valid16, out_ready16;
    logic [15:0] a16, b16;
    logic        in_ready16 [3];
    logic        out_valid16 [3];
    logic        dz16 [3];
    logic        busy16 [3];
    logic [15:0] q16 [3];
    logic [15:0] r16 [3];

    for (genvar g = 0; g < 3; g++) begin : g_w16
        subc_restoring_div #(.width(16), .speed(g)) dut (
            .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid16), .in_ready_o(in_ready16[g]),
            .dividend_i(a16), .divisor_i(b16), .out_valid_o(out_valid16[g]), .out_ready_i(out_ready16),
            .quotient_o(q16[g]), .remainder_o(r16[g]), .div_zero_o(dz16[g]), .busy_o(busy16[g])
        );
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input int hold);
        logic [7:0] eq, er;
        int lat, cyc;
        eq  = (b == 0) ? 8'hff : a / b;
        er  = (b == 0) ? a : a % b;
        lat = (b == 0 && FAST) ? 0 : 8;
        @(negedge clk);
        check("w8_in_ready_idle", in_ready8, 1);
        in_valid8 = 1'b1; a8 = a; b8 = b;
        @(posedge clk); #1;
        in_valid8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        cyc = 0;
        if (lat > 0) check("w8_in_ready_run", in_ready8, 0);
        while (!out_valid8 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("w8_latency", cyc, lat);
        check("w8_quotient", q8, eq);
        check("w8_remainder", r8, er);
        check("w8_div_zero", dz8, (b == 0));
        check("w8_busy_done", busy8, 1);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check("w8_hold_valid", out_valid8, 1);
            check("w8_hold_quotient", q8, eq);
            check("w8_hold_remainder", r8, er);
        end
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
        check("w8_valid_drop", out_valid8, 0);
        check("w8_in_ready_back", in_ready8, 1);
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] eq, er;
        int lat, cyc;
        eq  = (b == 0) ? 16'hffff : a / b;
        er  = (b == 0) ? a : a % b;
        lat = (b == 0 && FAST) ? 0 : 16;
        @(negedge clk);
        in_valid16 = 1'b1; a16 = a; b16 = b;
        @(posedge clk); #1;
        in_valid16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
        cyc = 0;
        while (!(out_valid16[0] && out_valid16[1] && out_valid16[2]) && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("w16_latency", cyc, lat);
        for (int s = 0; s < 3; s++) begin
            check("w16_quotient", q16[s], eq);
            check("w16_remainder", r16[s], er);
            check("w16_div_zero", dz16[s], (b == 0));
        end
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        out_ready16 = 1'b1;
        @(posedge clk); #1;
        out_ready16 = 1'b0;
        check("w16_valid_drop", out_valid16[0] | out_valid16[1] | out_valid16[2], 0);
    endtask

    initial begin
        logic [15:0] ra, rb;
        rst_n = 1'b0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0;
        in_valid16 = 1'b0; out_ready16 = 1'b0; a16 = '0; b16 = '0;
        #12;
        check("rst_in_ready", in_ready8, 1);
        check("rst_out_valid", out_valid8, 0);
        check("rst_busy", busy8, 0);
        check("rst_quotient", q8, 0);
        check("rst_remainder", r8, 0);
        check("rst_div_zero", dz8, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run8(8'd100, 8'd7, 5);
        run8(8'd255, 8'd1, 0);
        run8(8'd5, 8'd9, 0);
        run8(8'd37, 8'd0, 2);
        run8(8'd0, 8'd0, 0);
        run8(8'd254, 8'd255, 0);

        @(negedge clk);
        in_valid8 = 1'b1; a8 = 8'd200; b8 = 8'd3;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_quotient", q8, 0);
        check("abort_remainder", r8, 0);
        check("abort_out_valid", out_valid8, 0);
        check("abort_busy", busy8, 0);
        check("abort_in_ready", in_ready8, 1);
        @(negedge clk);
        rst_n = 1'b1;
        run8(8'd200, 8'd3, 0);

        for (int n = 0; n < 1200; n++) begin
            ra = 16'($urandom);
            if ($urandom_range(0, 15) == 0) rb = '0;
            else if ($urandom_range(0, 1) == 1) rb = 16'($urandom_range(1, 255));
            else rb = 16'($urandom);
            run16(ra, rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
